// File: rtl/ppc60x_burst_master.sv
// PowerPC 60x bus master: turns one local read/write request into a full
// bus tenure. The tenure covers arbitration, an address phase with retry, and a single- or burst-beat data phase.
module ppc60x_burst_master #(
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int BEATS     = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ,
  input  logic                REQ_WE,
  input  logic                REQ_BURST,
  input  logic [2:0]          REQ_SIZE,
  input  logic [AW-1:0]       REQ_ADDR,
  input  logic                REQ_WT,
  input  logic [BEATS*DW-1:0] WDATA,
  output logic [DW-1:0]       RDATA,
  output logic                RVALID,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic                BR,
  input  logic                BG,
  output logic                TS,
  output logic [AW-1:0]       A,
  output logic [4:0]          TT,
  output logic [2:0]          TSIZ,
  output logic                TBST,
  output logic                WT,
  output logic                ADDR_OE,
  input  logic                AACK,
  input  logic                ARTRY,
  input  logic                DBG,
  input  logic                TA,
  output logic [DW/2-1:0]     DH,
  output logic [DW/2-1:0]     DL,
  input  logic [DW/2-1:0]     DL_IN,
  input  logic [DW/2-1:0]     DH_IN,
  output logic                D_OE
);
  localparam int LB = $clog2(BEATS*DW/8);
  localparam int CW = $clog2(BEATS);
  localparam int RW = $clog2(MAX_RETRY+1);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSREQ, S_ADDR, S_AWIN, S_DWAIT, S_DATA, S_DONE
  } state_t;

  state_t                     r_state, w_next;
  logic                       r_we, r_burst, r_wt, r_ts;
  logic [2:0]                 r_size;
  logic [AW-1:0]              r_addr;
  logic [BEATS-1:0][DW-1:0]   r_line;
  logic [RW-1:0]              r_retry;
  logic [CW-1:0]              r_cnt;
  logic                       r_busy, r_done, r_err, r_rvalid;
  logic [DW-1:0]              r_rdata;
  logic                       w_last;
  logic [RW-1:0]              w_retry_inc;
  logic [AW-1:0]              w_line_addr;
  logic [DW-1:0]              w_beat;

  always_comb begin
    w_line_addr          = REQ_ADDR;
    w_line_addr[LB-1:0]  = '0;
  end

  assign w_last      = r_burst ? (r_cnt == CW'(BEATS-1)) : 1'b1;
  assign w_retry_inc = r_retry + RW'(1);
  assign w_beat      = r_line[r_cnt];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (REQ) w_next = S_BUSREQ;
      S_BUSREQ: if (!BG && ARTRY) w_next = S_ADDR;
      S_ADDR:   if (!AACK) w_next = S_AWIN;
      S_AWIN: begin
        if (!ARTRY) w_next = (w_retry_inc == RW'(MAX_RETRY)) ? S_IDLE : S_BUSREQ;
        else        w_next = S_DWAIT;
      end
      S_DWAIT:  if (!DBG) w_next = S_DATA;
      S_DATA:   if (!TA && w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_burst  <= 1'b0;
      r_wt     <= 1'b0;
      r_ts     <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_line   <= '0;
      r_retry  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      // TS marks only the first cycle of each address tenure
      r_ts     <= (w_next == S_ADDR) && (r_state != S_ADDR);
      case (r_state)
        S_IDLE: if (REQ) begin
          r_we    <= REQ_WE;
          r_burst <= REQ_BURST;
          r_wt    <= REQ_WT;
          r_size  <= REQ_SIZE;
          r_addr  <= REQ_BURST ? w_line_addr : REQ_ADDR;
          r_line  <= WDATA;
          r_retry <= '0;
          r_busy  <= 1'b1;
        end
        S_AWIN: if (!ARTRY) begin
          r_retry <= w_retry_inc;
          if (w_retry_inc == RW'(MAX_RETRY)) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_DWAIT: r_cnt <= '0;
        S_DATA: if (!TA) begin
          r_cnt <= r_cnt + CW'(1);
          if (!r_we) begin
            r_rdata  <= {DH_IN, DL_IN};
            r_rvalid <= 1'b1;
          end
          if (w_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign BR      = ~(r_state == S_BUSREQ);
  assign TS      = ~((r_state == S_ADDR) && r_ts);
  assign ADDR_OE = (r_state == S_ADDR);
  assign A       = r_addr;
  assign TT      = r_we ? 5'b00010 : 5'b01010;
  assign TSIZ    = r_burst ? 3'b010 : r_size;
  assign TBST    = ~r_burst;
  assign WT      = ~r_wt;
  assign D_OE    = (r_state == S_DATA) && r_we;
  assign DH      = w_beat[DW-1:DW/2];
  assign DL      = w_beat[DW/2-1:0];
  assign RDATA   = r_rdata;
  assign RVALID  = r_rvalid;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;
endmodule

// File: tb/tb_ppc60x_burst_master.sv
// Bench for ppc60x_burst_master: a behavioural 60x slave drives the bus with
// random or directed timing; expectations come from the request parameters.
module tb_ppc60x_burst_master;
  localparam int AW = 32, DW = 64, BEATS = 4, MAX_RETRY = 8;
  localparam int P_REQ = 0, P_ADDR = 1, P_AWIN = 2, P_DWAIT = 3, P_DATA = 4, P_END = 5;

  logic CLK = 1'b0, RST = 1'b1;
  logic REQ = 0, REQ_WE = 0, REQ_BURST = 0, REQ_WT = 0;
  logic [2:0] REQ_SIZE = '0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [BEATS*DW-1:0] WDATA = '0;
  logic [DW-1:0] RDATA;
  logic RVALID, BUSY, DONE, ERR, BR, TS, TBST, WT, ADDR_OE, D_OE;
  logic BG = 1, AACK = 1, ARTRY = 1, DBG = 1, TA = 1;
  logic [AW-1:0] A;
  logic [4:0] TT;
  logic [2:0] TSIZ;
  logic [DW/2-1:0] DH, DL, DH_IN = '0, DL_IN = '0;

  int n_chk = 0, n_pass = 0;

  ppc60x_burst_master #(.AW(AW), .DW(DW), .BEATS(BEATS), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_BURST(REQ_BURST),
    .REQ_SIZE(REQ_SIZE), .REQ_ADDR(REQ_ADDR), .REQ_WT(REQ_WT), .WDATA(WDATA),
    .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .BR(BR), .BG(BG), .TS(TS), .A(A), .TT(TT), .TSIZ(TSIZ), .TBST(TBST), .WT(WT),
    .ADDR_OE(ADDR_OE), .AACK(AACK), .ARTRY(ARTRY), .DBG(DBG), .TA(TA),
    .DH(DH), .DL(DL), .DL_IN(DL_IN), .DH_IN(DH_IN), .D_OE(D_OE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One full request. Slave inputs are low (active) except with stall_pct
  // chance; ARTRY is asserted in the first n_artry retry windows.
  task automatic do_txn(input bit we, input bit burst, input logic [2:0] size,
                        input logic [31:0] addr, input bit wt, input logic [255:0] line,
                        input int n_artry, input int stall_pct, input int stall_beat,
                        input int stall_n, input int rst_beat, input bit seq_rd,
                        output int lat);
    int ph, beat, nb, ts_cnt, rv_cnt, retries, stalls, cyc;
    bit l_aack, l_artry, l_dbg, l_ta, done, exp_err, quiet;
    logic [31:0] ea;
    logic [63:0] rq[$];
    nb = burst ? BEATS : 1;
    ea = burst ? (addr & ~32'h1F) : addr;
    exp_err = (n_artry >= MAX_RETRY);
    retries = n_artry; stalls = stall_n;
    ph = P_REQ; beat = 0; ts_cnt = 0; rv_cnt = 0; lat = -1; done = 0;
    l_aack = 1; l_artry = 1; l_dbg = 1; l_ta = 1;
    REQ = 1; REQ_WE = we; REQ_BURST = burst; REQ_SIZE = size; REQ_ADDR = addr;
    REQ_WT = wt; WDATA = line;
    @(posedge CLK); #1;
    REQ = 0; REQ_ADDR = $urandom; REQ_SIZE = 3'($urandom); REQ_WE = ~we; WDATA = '0;
    chk("busy_start", BUSY, 1);
    cyc = 1;
    while (!done && cyc <= 600) begin
      if (ph == P_ADDR && !l_aack) ph = P_AWIN;
      else if (ph == P_AWIN) ph = l_artry ? P_DWAIT : P_REQ;
      else if (ph == P_DWAIT && !l_dbg) begin ph = P_DATA; beat = 0; end
      else if (ph == P_DATA && !l_ta) begin beat++; if (beat == nb) ph = P_END; end
      if (!TS) begin
        ph = P_ADDR; ts_cnt++;
        chk("ts_addr", A, ea);
        chk("ts_tt", TT, we ? 5'b00010 : 5'b01010);
        chk("ts_tsiz", TSIZ, burst ? 3'b010 : size);
        chk("ts_tbst", TBST, !burst);
        chk("ts_wt", WT, !wt);
        chk("ts_oe_br", {ADDR_OE, BR}, 2'b11);
      end
      if (ph == P_DATA) begin
        chk("d_oe", D_OE, we);
        if (we) chk("wdata", {DH, DL}, line[beat*64 +: 64]);
      end
      if (RVALID) begin
        rv_cnt++;
        if (rq.size() == 0) chk("rvalid_extra", 1, 0);
        else chk("rdata", RDATA, rq.pop_front());
      end
      if (DONE) begin
        lat = cyc; done = 1;
        chk("err", ERR, exp_err);
        chk("ts_count", ts_cnt, exp_err ? MAX_RETRY : n_artry + 1);
        chk("beats", (ph == P_END) ? nb : beat, exp_err ? 0 : nb);
        chk("rv_count", rv_cnt, (we || exp_err) ? 0 : nb);
        chk("done_busy_doe", {BUSY, D_OE}, 2'b00);
      end else if (rst_beat >= 0 && ph == P_DATA && beat == rst_beat) begin
        RST = 1; TA = 1; BG = 1; AACK = 1; DBG = 1; ARTRY = 1;
        @(posedge CLK); #1;
        chk("rst_br_ts", {BR, TS}, 2'b11);
        chk("rst_oe", {ADDR_OE, D_OE}, 2'b00);
        chk("rst_busy_done", {BUSY, DONE}, 2'b00);
        RST = 0; quiet = 1;
        repeat (6) begin @(posedge CLK); #1; if (DONE || BUSY || !BR) quiet = 0; end
        chk("rst_quiet", quiet, 1);
        done = 1; lat = cyc;
      end else begin
        BG   = ($urandom_range(99) < stall_pct);
        AACK = ($urandom_range(99) < stall_pct);
        DBG  = ($urandom_range(99) < stall_pct);
        TA   = ($urandom_range(99) < stall_pct);
        REQ  = (stall_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
        ARTRY = 1;
        if (ph == P_AWIN && retries > 0) begin ARTRY = 0; retries--; end
        if (ph == P_DATA && beat == stall_beat && stalls > 0) begin TA = 1; stalls--; end
        if (seq_rd) begin DH_IN = '0; DL_IN = 32'(beat + 1); end
        else begin DH_IN = $urandom; DL_IN = $urandom; end
        if (ph == P_DATA && !TA && !we) rq.push_back({DH_IN, DL_IN});
        l_aack = AACK; l_artry = ARTRY; l_dbg = DBG; l_ta = TA;
        @(posedge CLK); #1;
        cyc++;
      end
    end
    if (!done) chk("timeout", 0, 1);
    REQ = 0; BG = 1; AACK = 1; ARTRY = 1; DBG = 1; TA = 1;
    @(posedge CLK); #1;
  endtask

  initial begin
    int lat;
    logic [255:0] ln;
    repeat (2) @(posedge CLK); #1;
    chk("rst_ctl", {BR, TS, TBST, WT}, 4'hF);
    chk("rst_oe", {ADDR_OE, D_OE, BUSY, DONE, ERR, RVALID}, 6'h0);
    chk("rst_rdata", RDATA, 0);
    RST = 0;
    @(posedge CLK); #1;

    ln = {64'hDDDD4444DDDD4444, 64'hCCCC3333CCCC3333, 64'hBBBB2222BBBB2222, 64'hAAAA1111AAAA1111};
    do_txn(1, 0, 3'b001, 32'hAAAAAAA8, 0, ln, 0, 0, -1, 0, -1, 0, lat);
    chk("lat_single_wr", lat, 6);
    do_txn(0, 1, 3'b000, 32'h1234_567C, 1, '0, 0, 0, -1, 0, -1, 1, lat);
    chk("lat_burst_rd", lat, 9);
    do_txn(1, 1, 3'b000, 32'h0000_1040, 0, ln, 0, 0, 1, 2, -1, 0, lat);
    chk("lat_burst_wr_stall", lat, 11);
    do_txn(1, 0, 3'b100, 32'h0000_2004, 0, ln, 2, 0, -1, 0, -1, 0, lat);
    chk("lat_retry2", lat, 12);
    do_txn(0, 1, 3'b000, 32'h0000_3000, 0, '0, MAX_RETRY, 0, -1, 0, -1, 0, lat);
    do_txn(1, 1, 3'b000, 32'h0000_4000, 0, ln, 0, 0, -1, 0, 2, 0, lat);

    for (int t = 0; t < 40; t++) begin
      ln = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_txn(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom), $urandom,
             1'($urandom_range(1)), ln,
             ($urandom_range(9) == 0) ? MAX_RETRY + 1 : $urandom_range(3),
             30, -1, 0, -1, 0, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
